target_coord_gen: RTL

Consumes the 4-bit random nibble stream from the random-number stage and turns it into a legal on-screen target grid coordinate (x, y) for the object-tracking game.
- Uses rejection sampling: out-of-range or repeated positions are discarded and new nibbles are drawn.
- Emits a one-cycle valid pulse with the coordinate, which the target renderer/tracker latches.

---
 rtl/target_coord_gen.sv | 137 +++++++++++++
 1 files changed

// File: rtl/target_coord_gen.sv
// -----------------------------------------------------------------------------
// target_coord_gen
// Turns the 4-bit random nibble stream into a legal, non-repeating target grid
// coordinate by rejection sampling. Each coordinate is built from two nibbles
// (high then low). The value is truncated to COORD_W bits and redrawn if it is
// out of range. A finished (x,y) pair that equals the last emitted target causes
// both coordinates to be redrawn.
//
// Ports
//   i_clk         system clock, rising edge
//   i_rst         synchronous active-high reset
//   i_start       request a new target (sampled only in IDLE)
//   i_rnd         random nibble
//   i_rnd_valid   i_rnd valid; consumed on every edge spent in a draw state
//   o_x, o_y      accepted coordinate, held until the next accept
//   o_valid       one-cycle pulse when o_x/o_y update
//   o_busy        high from start acceptance until the accept edge
//   o_reject_cnt  rejections for the current/last target, saturating at 255
// -----------------------------------------------------------------------------
module target_coord_gen #(
    parameter int X_MAX   = 39,
    parameter int Y_MAX   = 29,
    parameter int COORD_W = 6
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic [3:0]         i_rnd,
    input  logic               i_rnd_valid,
    output logic [COORD_W-1:0] o_x,
    output logic [COORD_W-1:0] o_y,
    output logic               o_valid,
    output logic               o_busy,
    output logic [7:0]         o_reject_cnt
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_X_HI  = 3'd1;
    localparam logic [2:0] S_X_LO  = 3'd2;
    localparam logic [2:0] S_Y_HI  = 3'd3;
    localparam logic [2:0] S_Y_LO  = 3'd4;
    localparam logic [2:0] S_CHECK = 3'd5;

    localparam logic [COORD_W-1:0] L_X_MAX = COORD_W'(X_MAX);
    localparam logic [COORD_W-1:0] L_Y_MAX = COORD_W'(Y_MAX);

    logic [2:0]         r_state;
    logic [3:0]         r_hi;        // high nibble of the coordinate being drawn
    logic [COORD_W-1:0] r_cx;
    logic [COORD_W-1:0] r_cy;
    logic               r_prev_vld;  // o_x/o_y hold a real target to avoid repeating

    // Candidate from {high nibble, current nibble}, truncated to COORD_W bits.
    logic [COORD_W-1:0] w_cand;
    logic               w_same;
    logic               w_draw;

    assign w_cand = COORD_W'({r_hi, i_rnd});
    assign w_same = r_prev_vld && (r_cx == o_x) && (r_cy == o_y);
    assign w_draw = i_rnd_valid;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_hi         <= 4'd0;
            r_cx         <= '0;
            r_cy         <= '0;
            r_prev_vld   <= 1'b0;
            o_x          <= '0;
            o_y          <= '0;
            o_valid      <= 1'b0;
            o_busy       <= 1'b0;
            o_reject_cnt <= 8'd0;
        end else begin
            o_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state      <= S_X_HI;
                        o_busy       <= 1'b1;
                        o_reject_cnt <= 8'd0;
                    end
                end
                S_X_HI: begin
                    if (w_draw) begin
                        r_hi    <= i_rnd;
                        r_state <= S_X_LO;
                    end
                end
                S_X_LO: begin
                    if (w_draw) begin
                        if (w_cand > L_X_MAX) begin
                            if (o_reject_cnt != 8'hFF) o_reject_cnt <= o_reject_cnt + 8'd1;
                            r_state <= S_X_HI;
                        end else begin
                            r_cx    <= w_cand;
                            r_state <= S_Y_HI;
                        end
                    end
                end
                S_Y_HI: begin
                    if (w_draw) begin
                        r_hi    <= i_rnd;
                        r_state <= S_Y_LO;
                    end
                end
                S_Y_LO: begin
                    if (w_draw) begin
                        // A y reject keeps the latched x and redraws y only.
                        if (w_cand > L_Y_MAX) begin
                            if (o_reject_cnt != 8'hFF) o_reject_cnt <= o_reject_cnt + 8'd1;
                            r_state <= S_Y_HI;
                        end else begin
                            r_cy    <= w_cand;
                            r_state <= S_CHECK;
                        end
                    end
                end
                S_CHECK: begin
                    if (w_same) begin
                        if (o_reject_cnt != 8'hFF) o_reject_cnt <= o_reject_cnt + 8'd1;
                        r_state <= S_X_HI;
                    end else begin
                        o_x        <= r_cx;
                        o_y        <= r_cy;
                        o_valid    <= 1'b1;
                        r_prev_vld <= 1'b1;
                        o_busy     <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
